// File: rtl/dsi_hdr_arb_pkg.sv
// dsi_hdr_arb_pkg: shared FSM states, DSI data types, header layout and ECC parity function.
package dsi_hdr_arb_pkg;
  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;
  localparam logic [5:0] DT_DCS_SW0 = 6'h05;
  localparam logic [5:0] DT_DCS_SW1 = 6'h15;
  localparam logic [5:0] DT_DCS_LW  = 6'h39;
  localparam int HDR_DI_LSB  = 0;
  localparam int HDR_WC_LSB  = 8;
  localparam int HDR_ECC_LSB = 24;
  // Each parity bit is the XOR of the header bits selected by its mask.
  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction
endpackage

// File: rtl/dsi_hdr_ecc_calc.sv
// dsi_hdr_ecc_calc: registered 24-to-8 DSI header ECC with load enable.
module dsi_hdr_ecc_calc
  import dsi_hdr_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] data,
  output logic [7:0]  ecc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) ecc <= '0;
    else if (en) ecc <= ecc_calc(data);
endmodule

// File: rtl/dsi_hdr_arb.sv
// dsi_hdr_arb: two-requester DSI short-header arbiter; define HDR_ARB_RR_EN for round-robin, else req0 has fixed priority.
module dsi_hdr_arb
  import dsi_hdr_arb_pkg::*;
#(
  parameter logic [1:0] VC = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [5:0]  req0_dt,
  input  logic [15:0] req0_wc,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [5:0]  req1_dt,
  input  logic [15:0] req1_wc,
  output logic        req1_ready,
  output logic        hdr_valid,
  output logic [31:0] hdr_data,
  output logic        hdr_src,
  input  logic        hdr_ready,
  output logic        busy
);
  state_t      state;
  logic [7:0]  di;
  logic [15:0] wc;
  logic [7:0]  ecc;
  logic        gnt1;
  logic        accept;
`ifdef HDR_ARB_RR_EN
  logic pref1;
  always_ff @(posedge clk or posedge rst)
    if (rst) pref1 <= 1'b0;
    else if (accept) pref1 <= !gnt1;
  assign gnt1 = req1_valid && (!req0_valid || pref1);
`else
  assign gnt1 = !req0_valid;
`endif
  // Ready is a same-cycle accept pulse, so it is decoded from state rather than registered.
  assign accept     = !rst && state == IDLE && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt1;
  assign req1_ready = accept && gnt1;
  assign busy       = state != IDLE;
  assign hdr_data[HDR_DI_LSB +: 8]   = di;
  assign hdr_data[HDR_WC_LSB +: 16]  = wc;
  assign hdr_data[HDR_ECC_LSB +: 8]  = ecc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      hdr_valid <= 1'b0;
      hdr_src   <= 1'b0;
      di        <= '0;
      wc        <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          di      <= {VC, gnt1 ? req1_dt : req0_dt};
          wc      <= gnt1 ? req1_wc : req0_wc;
          hdr_src <= gnt1;
          state   <= CALC;
        end
        CALC: begin
          hdr_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (hdr_ready) begin
          hdr_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  dsi_hdr_ecc_calc u_ecc (
    .clk  (clk),
    .rst  (rst),
    .en   (state == CALC),
    .data ({wc, di}),
    .ecc  (ecc)
  );
endmodule

// File: tb/tb_dsi_hdr_arb.sv
// tb_dsi_hdr_arb: directed and random checks of dsi_hdr_arb against a column-code ECC and arbitration model.
module tb_dsi_hdr_arb;
  import dsi_hdr_arb_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, hdr_ready = 1'b0;
  logic [5:0]  req0_dt = '0, req1_dt = '0;
  logic [15:0] req0_wc = '0, req1_wc = '0;
  logic        req0_ready, req1_ready, hdr_valid, hdr_src, busy;
  logic [31:0] hdr_data;
  int vectors = 0, miscompares = 0;
  bit pref1 = 1'b0;
  // Hamming column code of each header bit: which ECC bits it feeds.
  logic [5:0] col [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                           6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                           6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  dsi_hdr_arb #(.VC(2'd0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dt(req0_dt), .req0_wc(req0_wc), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dt(req1_dt), .req1_wc(req1_wc), .req1_ready(req1_ready),
    .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_src(hdr_src), .hdr_ready(hdr_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_hdr(input logic [5:0] dt, input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  s;
    d = {wc, 2'b00, dt};
    s = '0;
    for (int i = 0; i < 24; i++) if (d[i]) s ^= col[i];
    return {2'b00, s, wc, 2'b00, dt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Called with requests set up in an IDLE cycle; walks one header through accept, CALC, SEND and handshake.
  task automatic run_hdr(input bit exp_src, input int stall, input bit refill, input logic [31:0] lit);
    logic [31:0] e;
    #1;
    chk("grant", {req1_ready, req0_ready}, exp_src ? 2'b10 : 2'b01);
    e = exp_src ? exp_hdr(req1_dt, req1_wc) : exp_hdr(req0_dt, req0_wc);
    if (lit != 0) e = lit;
    pref1 = !exp_src;
    step;
    if (exp_src) begin
      if (refill) begin req1_dt = 6'($urandom); req1_wc = 16'($urandom); end
      else req1_valid = 1'b0;
    end else begin
      if (refill) begin req0_dt = 6'($urandom); req0_wc = 16'($urandom); end
      else req0_valid = 1'b0;
    end
    hdr_ready = (stall == 0);
    #1 chk("calc", {busy, hdr_valid, req1_ready, req0_ready}, 4'b1000);
    step;
    #1;
    chk("hdr_data", hdr_data, e);
    chk("ecc76", hdr_data[31:30], 2'b00);
    chk("hdr_src", hdr_src, exp_src);
    chk("send", {busy, hdr_valid, req1_ready, req0_ready}, 4'b1100);
    for (int i = 0; i < stall; i++) begin
      step;
      #1;
      chk("stall_data", hdr_data, e);
      chk("stall_src", hdr_src, exp_src);
      chk("stall_ctl", {busy, hdr_valid, req1_ready, req0_ready}, 4'b1100);
    end
    hdr_ready = 1'b1;
    step;
    #1 chk("idle", {busy, hdr_valid}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e_src;
    req0_valid = 1'b1; req0_dt = DT_DCS_LW; req0_wc = 16'h1234; hdr_ready = 1'b1;
    step; step;
    #1;
    chk("rst_ctl", {hdr_valid, hdr_src, req1_ready, req0_ready, busy}, 5'b0);
    chk("rst_data", hdr_data, 32'h0);
    req0_valid = 1'b0;
    rst = 1'b0;
    step;
    req1_valid = 1'b1; req1_dt = DT_DCS_SW0; req1_wc = 16'h0011;
    run_hdr(1'b1, 0, 1'b0, 32'h36001105);
    req0_valid = 1'b1; req0_dt = DT_DCS_SW1; req0_wc = 16'h00A5;
    req1_valid = 1'b1; req1_dt = DT_DCS_LW;  req1_wc = 16'h0100;
    for (int i = 0; i < 4; i++) begin
`ifdef HDR_ARB_RR_EN
      run_hdr(i[0], 0, 1'b1, 0);
`else
      run_hdr(1'b0, 0, 1'b1, 0);
`endif
    end
    req0_valid = 1'b0;
    run_hdr(1'b1, 0, 1'b0, 0);
    req0_valid = 1'b1; req0_dt = DT_DCS_LW; req0_wc = 16'hBEEF;
    run_hdr(1'b0, 10, 1'b0, 0);
    req0_valid = 1'b1; req0_dt = DT_DCS_SW1; req0_wc = 16'h5A5A;
    #1 chk("pre_rst_grant", {req1_ready, req0_ready}, 2'b01);
    step;
    rst = 1'b1;
    #1 chk("rst_calc", {hdr_valid, hdr_src, req1_ready, req0_ready, busy}, 5'b0);
    chk("rst_calc_data", hdr_data, 32'h0);
    step;
    #1 chk("rst_hold", {hdr_valid, req1_ready, req0_ready, busy}, 4'b0);
    rst = 1'b0;
    pref1 = 1'b0;
    req0_dt = DT_DCS_SW0; req0_wc = 16'h0C3C;
    run_hdr(1'b0, 0, 1'b0, 0);
    for (int n = 0; n < 1000; n++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_dt = 6'($urandom); req0_wc = 16'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_dt = 6'($urandom); req1_wc = 16'($urandom);
      end
      if (!req0_valid && !req1_valid) begin
        req0_valid = 1'b1; req0_dt = 6'($urandom); req0_wc = 16'($urandom);
      end
`ifdef HDR_ARB_RR_EN
      e_src = (req0_valid && req1_valid) ? pref1 : req1_valid;
`else
      e_src = !req0_valid;
`endif
      run_hdr(e_src, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
